rotate_seq_ctrl: RTL and testbench
==================================

// Module: rotate_seq_ctrl
// PURPOSE
//   Upstream sequencer for the 8-bit rotate-right barrel shifter. Holds a pattern
//   and steps the rotate amount at a programmable rate, producing the shifter's
//   a/amt inputs for LED-chase style displays.
//   Supports free-run and single-step modes, both rotate directions, and a wrap
//   pulse each time amt completes a full revolution.
// PARAMETERS
//   DW     8    pattern width; must be a power of 2 (equals the shifter width)
//   AW     3    amount width = log2(DW)
//   DIV_W  16   prescaler width
// PORTS
//   clk       in   1      system clock; all state on rising edge
//   reset_n   in   1      asynchronous active-low reset
//   load      in   1      1-cycle strobe: a <= pat_in, amt <= 0
//   pat_in    in   DW     pattern to load
//   start     in   1      1-cycle strobe: IDLE -> RUN
//   stop      in   1      1-cycle strobe: RUN -> IDLE
//   step      in   1      1-cycle strobe: single advance, honoured only in IDLE
//   dir       in   1      0: amt increments; 1: amt decrements
//   step_div  in   DIV_W  RUN advances once every step_div+1 cycles
//   a         out  DW     pattern to shifter (registered)
//   amt       out  AW     rotate amount to shifter (registered)
//   running   out  1      1 while in RUN
//   wrap      out  1      1-cycle pulse on amt wrap-around
// BEHAVIOUR
//   - Reset (async assert, sync release): state=IDLE, a=0, amt=0, cnt=0,
//     running=0, wrap=0.
//   - FSM states: IDLE, RUN. running = (state==RUN), registered.
//     - IDLE + start & !stop -> RUN, with cnt <= 0.
//     - RUN + stop -> IDLE, with cnt <= 0.
//     - start & stop in the same cycle -> IDLE (stop wins).
//     - start in RUN and stop in IDLE are ignored.
//   - Prescaler (RUN only): cnt counts up. When cnt >= step_div, adv=1 and
//     cnt <= 0; otherwise cnt <= cnt+1.
//     - step_div=0: advance every cycle.
//     - step_div lowered below cnt: advance on the next cycle.
//     - cnt holds at 0 in IDLE.
//   - Advance also occurs in IDLE when step=1. step in RUN is ignored.
//   - On advance: amt <= amt+1 (dir=0) or amt-1 (dir=1), modulo 2^AW.
//     - Visible on amt the cycle after the advance condition.
//     - dir is sampled in the advance cycle.
//   - wrap = 1 for exactly one cycle, coincident with the amt update, when amt
//     goes 7->0 (dir=0) or 0->7 (dir=1). Otherwise 0.
//   - load (any state): a <= pat_in, amt <= 0, cnt <= 0, and the FSM state is
//     unchanged.
//     - load beats a same-cycle advance: no amt step and no wrap.
//     - start with load: both take effect.
//   - a changes only on load. Downstream y = a rotated right by amt, so it lags
//     the controls by 1 cycle plus combinational delay.
//   - Reset asserted mid-RUN returns all outputs to reset values at once. No
//     pending advance or wrap survives reset.
// TESTING
//   1. Reset, then load pat_in=8'h81 -> next cycle a=8'h81, amt=0, running=0,
//      wrap=0.
//   2. step_div=3, start, dir=0 -> amt increments every 4 cycles: 0,1,..,7,0.
//      wrap=1 only on the 7->0 cycle. running=1 throughout.
//   3. IDLE, dir=1, amt=0, step pulse -> amt=7 and wrap=1 the next cycle.
//      step held during RUN -> no extra advances.
//   4. RUN, step_div=0, load asserted on an advance cycle with amt=7 ->
//      amt=0, wrap=0, a=pat_in, running still 1.
//   5. start and stop in the same cycle from IDLE -> stays IDLE.
//      stop in RUN -> running=0, and amt frozen at its current value.
//   6. reset_n pulled low mid-RUN, asynchronously between edges -> a=0, amt=0,
//      running=0 before the next edge. After release, no step until start.

Source files
------------

// File: rtl/rotate_seq_ctrl.sv
// rotate_seq_ctrl: steps a rotate amount for an 8-bit rotate-right shifter,
// free-running on a prescaler or single-stepped, with a wrap pulse per revolution.
module rotate_seq_ctrl #(
    parameter int DW    = 8,
    parameter int AW    = 3,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [DW-1:0]    pat_in,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic             dir,
    input  logic [DIV_W-1:0] step_div,
    output logic [DW-1:0]    a,
    output logic [AW-1:0]    amt,
    output logic             running,
    output logic             wrap
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t           state_q, state_d;
    logic [DW-1:0]    a_q, a_d;
    logic [AW-1:0]    amt_q, amt_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             adv;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            amt_q   <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            amt_q   <= amt_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
        end
    end
    // stop has priority over start; each is ignored in the state it would not leave
    always_comb state_d = stop ? IDLE : (start ? RUN : state_q);
    always_comb begin
        running = state_q == RUN;
        adv     = running ? (cnt_q >= step_div) : step;
        a       = a_q;
        amt     = amt_q;
        wrap    = wrap_q;
    end
    // load overrides any same-cycle advance and restarts the prescaler
    always_comb begin
        a_d    = load ? pat_in : a_q;
        amt_d  = load ? '0 : (adv ? (dir ? amt_q - AW'(1) : amt_q + AW'(1)) : amt_q);
        wrap_d = adv & ~load & (dir ? amt_q == '0 : amt_q == '1);
        cnt_d  = (running & ~stop & ~load & ~adv) ? cnt_q + DIV_W'(1) : '0;
    end
endmodule

// File: tb/tb_rotate_seq_ctrl.sv
// tb_rotate_seq_ctrl: directed and random stimulus; a reference model queues the
// expected outputs each edge and a separate monitor compares them mid-cycle.
module tb_rotate_seq_ctrl;
    localparam int DW = 8;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic        load = 0, start = 0, stop = 0, step = 0, dir = 0;
    logic [7:0]  pat_in = '0;
    logic [15:0] step_div = '0;
    logic [7:0]  a;
    logic [2:0]  amt;
    logic        running, wrap;

    rotate_seq_ctrl dut (
        .clk(clk), .reset_n(reset_n), .load(load), .pat_in(pat_in), .start(start),
        .stop(stop), .step(step), .dir(dir), .step_div(step_div), .a(a), .amt(amt),
        .running(running), .wrap(wrap)
    );

    always #5 clk = ~clk;

    typedef struct {logic [7:0] a; int amt; bit run; bit wrap;} exp_t;
    exp_t q[$];
    int errors = 0, checks = 0;

    // reference model state
    bit         m_run = 0;
    logic [7:0] m_a = 0;
    int         m_amt = 0, m_cnt = 0;

    always @(negedge reset_n) begin
        q.delete();
        m_run = 0; m_a = 0; m_amt = 0; m_cnt = 0;
    end

    always @(posedge clk) begin
        if (reset_n) begin
            bit adv, wr;
            int t;
            exp_t e;
            adv = m_run ? (m_cnt >= int'(step_div)) : step;
            wr  = 0;
            if (load) begin
                m_a   = pat_in;
                m_amt = 0;
            end else if (adv) begin
                t     = m_amt + (dir ? -1 : 1);
                wr    = (t < 0) || (t >= DW);
                m_amt = (t + DW) % DW;
            end
            if (!m_run || stop || load || adv) m_cnt = 0;
            else m_cnt = m_cnt + 1;
            if (stop) m_run = 0;
            else if (start) m_run = 1;
            e.a = m_a; e.amt = m_amt; e.run = m_run; e.wrap = wr;
            q.push_back(e);
        end
    end

    task automatic cmp(string name, exp_t e);
        checks++;
        if (a !== e.a || int'(amt) !== e.amt || running !== e.run || wrap !== e.wrap) begin
            errors++;
            $display("FAIL %s t=%0t: got a=%h amt=%0d running=%b wrap=%b, expected a=%h amt=%0d running=%b wrap=%b",
                     name, $time, a, amt, running, wrap, e.a, e.amt, e.run, e.wrap);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            e.a = 0; e.amt = 0; e.run = 0; e.wrap = 0;
            cmp("reset", e);
        end else if (q.size() > 0) begin
            e = q.pop_front();
            cmp("cycle", e);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        load = 0; start = 0; stop = 0; step = 0;
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        exp_t z;
        int   guard;
        z.a = 0; z.amt = 0; z.run = 0; z.wrap = 0;
        ticks(3);
        reset_n = 1;
        tick();
        // load pattern
        load = 1; pat_in = 8'h81;
        tick(); tick();
        // free run, increment every 4 cycles through a full revolution
        step_div = 3; dir = 0; start = 1;
        ticks(36);
        stop = 1;
        tick();
        // single-step backwards from 0, then step held while running does nothing
        load = 1; pat_in = 8'h0F;
        tick();
        dir = 1; step = 1;
        tick(); tick();
        step_div = 20; start = 1;
        tick();
        for (int i = 0; i < 10; i++) begin step = 1; tick(); end
        // advance every cycle, load exactly when amt is 7
        step_div = 0; dir = 0;
        tick();
        guard = 0;
        while (m_amt != 7 && guard < 20) begin tick(); guard++; end
        checks++;
        if (m_amt != 7) begin errors++; $display("FAIL amt7_reach: got amt=%0d expected 7", m_amt); end
        load = 1; pat_in = 8'hA5;
        tick(); tick();
        // stop freezes amt; start with stop from idle stays idle
        stop = 1;
        tick(); ticks(3);
        start = 1; stop = 1;
        tick(); ticks(3);
        // async reset mid-run
        step_div = 1; start = 1;
        ticks(7);
        #2 reset_n = 0;
        #1 cmp("async_reset", z);
        ticks(2);
        reset_n = 1;
        ticks(5);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            load  = ($urandom_range(0, 15) == 0);
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 15) == 0);
            step  = ($urandom_range(0, 3) == 0);
            dir   = $urandom_range(0, 1);
            pat_in = 8'($urandom);
            if ($urandom_range(0, 9) == 0) step_div = 16'($urandom_range(0, 5));
            @(posedge clk);
            #1;
        end
        load = 0; start = 0; stop = 0; step = 0;
        tick();
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL drain: got %0d pending expected 0", q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
